// File: rtl/imem_boot_sequencer_pkg.sv
// Shared types and defaults for the instruction memory boot sequencer.
package imem_boot_sequencer_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 32;
    localparam int IMEM_DEPTH = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/imem_boot_sequencer_imem_port_mux.sv
// Steers the single instruction memory port between the loader and the core.
module imem_port_mux
    import imem_boot_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        state,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = fetch_addr;
        mem_wdata = load_data;
        case (state)
            ST_LOAD: begin
                mem_we   = load_we;
                mem_addr = load_addr;
            end
            default: begin
                mem_we   = 1'b0;
                mem_addr = fetch_addr;
            end
        endcase
    end

endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer: loads the instruction memory, holds the core in reset,
// then serves fetches with one cycle of latency.
module imem_boot_sequencer
    import imem_boot_sequencer_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LOAD_WORDS   = IMEM_DEPTH,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_we,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_start,
    input  logic              i_reload,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_valid,
    output logic [DATA_W-1:0] o_fetch_instr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_rst_n,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_drop_err,
    output logic [1:0]        o_state
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(LOAD_WORDS);

    state_t            state;
    logic              prev_we;
    logic [DW-1:0]     drain;
    logic [DATA_W-1:0] held;
    logic              rise;
    logic              full;

    assign rise    = i_load_we & ~prev_we;
    assign full    = (o_load_count == CNT_MAX);
    assign o_state = state;

    // Memory output is already registered; pass it straight through while valid.
    assign o_fetch_instr = o_fetch_valid ? i_mem_rdata : held;

    imem_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .state     (state),
        .load_we   (i_load_we),
        .load_addr (i_load_addr),
        .load_data (i_load_data),
        .fetch_addr(i_fetch_addr),
        .mem_we    (o_mem_we),
        .mem_addr  (o_mem_addr),
        .mem_wdata (o_mem_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_LOAD;
            prev_we       <= 1'b0;
            drain         <= '0;
            held          <= '0;
            o_fetch_valid <= 1'b0;
            o_cpu_rst_n   <= 1'b0;
            o_load_count  <= '0;
            o_drop_err    <= 1'b0;
        end else begin
            prev_we       <= i_load_we;
            o_fetch_valid <= 1'b0;
            if (o_fetch_valid) held <= i_mem_rdata;
            case (state)
                ST_LOAD: begin
                    if (i_reload) begin
                        o_load_count <= '0;
                        o_drop_err   <= 1'b0;
                    end else begin
                        if (rise && !full) o_load_count <= o_load_count + 1'b1;
                        if (i_start || (full && !i_load_we)) begin
                            state <= ST_DRAIN;
                            drain <= DRAIN_MAX;
                        end
                    end
                end
                ST_DRAIN, ST_RUN: begin
                    if (i_reload) begin
                        state        <= ST_LOAD;
                        o_cpu_rst_n  <= 1'b0;
                        o_load_count <= '0;
                        o_drop_err   <= 1'b0;
                    end else begin
                        if (rise) o_drop_err <= 1'b1;
                        if (state == ST_RUN) begin
                            o_fetch_valid <= i_fetch_req;
                        end else if (drain == '0) begin
                            state       <= ST_RUN;
                            o_cpu_rst_n <= 1'b1;
                        end else begin
                            drain <= drain - 1'b1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer with a synchronous memory model.
module tb_imem_boot_sequencer;

    logic        clk;
    logic        rst;
    logic        i_load_we;
    logic [2:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic        i_start;
    logic        i_reload;
    logic        i_fetch_req;
    logic [2:0]  i_fetch_addr;
    logic        o_fetch_valid;
    logic [31:0] o_fetch_instr;
    logic        o_mem_we;
    logic [2:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        o_cpu_rst_n;
    logic [3:0]  o_load_count;
    logic        o_drop_err;
    logic [1:0]  o_state;

    logic [31:0] mem [8];
    int errors;
    int checks;

    imem_boot_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_we    (i_load_we),
        .i_load_addr  (i_load_addr),
        .i_load_data  (i_load_data),
        .i_start      (i_start),
        .i_reload     (i_reload),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_addr (i_fetch_addr),
        .o_fetch_valid(o_fetch_valid),
        .o_fetch_instr(o_fetch_instr),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_cpu_rst_n  (o_cpu_rst_n),
        .o_load_count (o_load_count),
        .o_drop_err   (o_drop_err),
        .o_state      (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first synchronous memory, one cycle read latency
    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
        i_mem_rdata <= mem[o_mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [2:0] a, input logic [31:0] d, input int n);
        i_load_addr = a;
        i_load_data = d;
        i_load_we   = 1'b1;
        repeat (n) tick();
        i_load_we = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (o_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", o_state);
        end
        checks++;
        if (o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_rst_n got %b want 0", o_cpu_rst_n);
        end
        checks++;
        if (o_fetch_valid !== 1'b0 || o_fetch_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch got %b/%h want 0/0", o_fetch_valid, o_fetch_instr);
        end
        checks++;
        if (o_load_count !== 4'd0 || o_drop_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_count_err got %0d/%b want 0/0", o_load_count, o_drop_err);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_full_load;
        i_load_addr = 3'd0;
        i_load_data = 32'h13;
        i_load_we   = 1'b1;
        #1;
        checks++;
        if (o_mem_we !== 1'b1 || o_mem_addr !== 3'd0 || o_mem_wdata !== 32'h13) begin
            errors++;
            $display("FAIL load_forward got %b/%0d/%h want 1/0/00000013", o_mem_we, o_mem_addr, o_mem_wdata);
        end
        for (int i = 0; i < 7; i++) burst(3'(i), 32'h13 + 32'(i), 3);
        checks++;
        if (o_load_count !== 4'd7 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL load_count7 got %0d/%0d want 7/0", o_load_count, o_state);
        end
        burst(3'd7, 32'h1a, 3);
        checks++;
        if (o_load_count !== 4'd8 || o_state !== 2'd1 || o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL load_done got %0d/%0d/%b want 8/1/0", o_load_count, o_state, o_cpu_rst_n);
        end
        tick();
        checks++;
        if (o_state !== 2'd1 || o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL drain2 got %0d/%b want 1/0", o_state, o_cpu_rst_n);
        end
        tick();
        checks++;
        if (o_state !== 2'd2 || o_cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL run_entry got %0d/%b want 2/1", o_state, o_cpu_rst_n);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3];
        exp[0] = 32'h13;
        exp[1] = 32'h14;
        exp[2] = 32'h15;
        checks++;
        if (o_fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got %b want 0", o_fetch_valid);
        end
        i_fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_fetch_addr = 3'(i);
            #1;
            checks++;
            if (o_mem_addr !== 3'(i) || o_mem_we !== 1'b0) begin
                errors++;
                $display("FAIL fetch_addr%0d got %0d/%b want %0d/0", i, o_mem_addr, o_mem_we, i);
            end
            tick();
            checks++;
            if (o_fetch_valid !== 1'b1 || o_fetch_instr !== exp[i]) begin
                errors++;
                $display("FAIL b2b%0d got %b/%h want 1/%h", i, o_fetch_valid, o_fetch_instr, exp[i]);
            end
        end
        i_fetch_req = 1'b0;
        tick();
        checks++;
        if (o_fetch_valid !== 1'b0 || o_fetch_instr !== 32'h15) begin
            errors++;
            $display("FAIL fetch_hold got %b/%h want 0/00000015", o_fetch_valid, o_fetch_instr);
        end
    endtask

    task automatic test_drop_err;
        i_load_addr = 3'd2;
        i_load_data = 32'hdeadbeef;
        i_load_we   = 1'b1;
        #1;
        checks++;
        if (o_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_write got %b want 0", o_mem_we);
        end
        tick();
        checks++;
        if (o_drop_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_err got %b want 1", o_drop_err);
        end
        tick();
        i_load_we = 1'b0;
        tick();
        i_fetch_req  = 1'b1;
        i_fetch_addr = 3'd2;
        tick();
        i_fetch_req = 1'b0;
        checks++;
        if (o_fetch_valid !== 1'b1 || o_fetch_instr !== 32'h15 || o_drop_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_readback got %b/%h/%b want 1/00000015/1", o_fetch_valid, o_fetch_instr, o_drop_err);
        end
        tick();
    endtask

    task automatic test_reload_inflight;
        i_fetch_req  = 1'b1;
        i_fetch_addr = 3'd1;
        i_reload     = 1'b1;
        tick();
        i_fetch_req = 1'b0;
        i_reload    = 1'b0;
        checks++;
        if (o_fetch_valid !== 1'b0 || o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reload_fetch got %b/%b want 0/0", o_fetch_valid, o_cpu_rst_n);
        end
        checks++;
        if (o_load_count !== 4'd0 || o_drop_err !== 1'b0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL reload_state got %0d/%b/%0d want 0/0/0", o_load_count, o_drop_err, o_state);
        end
    endtask

    task automatic test_start;
        logic [31:0] exp [8];
        i_start  = 1'b1;
        i_reload = 1'b1;
        tick();
        i_start  = 1'b0;
        i_reload = 1'b0;
        checks++;
        if (o_state !== 2'd0) begin
            errors++;
            $display("FAIL reload_beats_start got %0d want 0", o_state);
        end
        burst(3'd0, 32'h100, 3);
        burst(3'd1, 32'h101, 3);
        i_load_addr = 3'd2;
        i_load_data = 32'h102;
        i_load_we   = 1'b1;
        i_start     = 1'b1;
        #1;
        checks++;
        if (o_mem_we !== 1'b1) begin
            errors++;
            $display("FAIL start_forward got %b want 1", o_mem_we);
        end
        tick();
        i_load_we = 1'b0;
        i_start   = 1'b0;
        checks++;
        if (o_state !== 2'd1 || o_load_count !== 4'd3) begin
            errors++;
            $display("FAIL start_drain got %0d/%0d want 1/3", o_state, o_load_count);
        end
        tick();
        tick();
        checks++;
        if (o_state !== 2'd2 || o_cpu_rst_n !== 1'b1 || o_load_count !== 4'd3) begin
            errors++;
            $display("FAIL start_run got %0d/%b/%0d want 2/1/3", o_state, o_cpu_rst_n, o_load_count);
        end
        exp[0] = 32'h100;
        exp[1] = 32'h101;
        exp[2] = 32'h102;
        exp[3] = 32'h16;
        exp[4] = 32'h17;
        exp[5] = 32'h18;
        exp[6] = 32'h19;
        exp[7] = 32'h1a;
        i_fetch_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_fetch_addr = 3'(i);
            tick();
            checks++;
            if (o_fetch_valid !== 1'b1 || o_fetch_instr !== exp[i]) begin
                errors++;
                $display("FAIL partial_read%0d got %b/%h want 1/%h", i, o_fetch_valid, o_fetch_instr, exp[i]);
            end
        end
        i_fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_drain;
        i_reload = 1'b1;
        tick();
        i_reload = 1'b0;
        burst(3'd0, 32'h100, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_state !== 2'd1 || o_load_count !== 4'd1) begin
            errors++;
            $display("FAIL pre_rst_drain got %0d/%0d want 1/1", o_state, o_load_count);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (o_state !== 2'd0 || o_cpu_rst_n !== 1'b0 || o_load_count !== 4'd0) begin
            errors++;
            $display("FAIL async_rst got %0d/%b/%0d want 0/0/0", o_state, o_cpu_rst_n, o_load_count);
        end
        checks++;
        if (o_fetch_valid !== 1'b0 || o_fetch_instr !== 32'h0 || o_drop_err !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_fetch got %b/%h/%b want 0/0/0", o_fetch_valid, o_fetch_instr, o_drop_err);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_load_count !== 4'd0) begin
            errors++;
            $display("FAIL post_rst got %0d/%0d want 0/0", o_state, o_load_count);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        i_load_we    = 1'b0;
        i_load_addr  = '0;
        i_load_data  = '0;
        i_start      = 1'b0;
        i_reload     = 1'b0;
        i_fetch_req  = 1'b0;
        i_fetch_addr = '0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        test_reset();
        test_full_load();
        test_back_to_back();
        test_drop_err();
        test_reload_inflight();
        test_start();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
Owns the single port of the 8-word instruction memory and sequences processor boot. In LOAD it passes UART loader writes to the memory and holds the CPU core in reset. Once the program is complete it releases the core and serves instruction fetches with 1-cycle read latency. A reload command returns it to LOAD.

Parameters:
ADDR_W, 3, instruction memory address width.
DATA_W, 32, instruction word width.
LOAD_WORDS, 8, distinct write bursts that complete a program load (1..2**ADDR_W).
DRAIN_CYCLES, 2, settle cycles between the last load write and core release (>=1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
i_load_we  in  1  loader write enable; may stay high for several cycles per word
i_load_addr  in  ADDR_W  loader write address
i_load_data  in  DATA_W  loader write data
i_start  in  1  1-cycle pulse; force run before LOAD_WORDS is reached
i_reload  in  1  1-cycle pulse; return to LOAD
i_fetch_req  in  1  core fetch request
i_fetch_addr  in  ADDR_W  core fetch word address
o_fetch_valid  out  1  fetch data valid, 1 cycle after accepted request
o_fetch_instr  out  DATA_W  fetched instruction
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, synchronous, 1-cycle latency
o_cpu_rst_n  out  1  core reset, active low, registered
o_load_count  out  ADDR_W+1  completed load bursts
o_drop_err  out  1  sticky: loader write seen outside LOAD
o_state  out  2  current state encoding

Behaviour:
- Reset mid-operation has the same effect at any time. Reset values: state=LOAD, o_cpu_rst_n=0, o_fetch_valid=0, o_fetch_instr=0, o_load_count=0, o_drop_err=0, drain counter=0, prev_we=0.
- States: LOAD=0, DRAIN=1, RUN=2. Encoding 3 is unused; if reached, next state is LOAD.
- Burst detection: prev_we registers i_load_we. A burst is counted on the rising edge only: i_load_we=1 and prev_we=0. A long-held enable therefore counts once.
- LOAD state:
  - o_mem_we = i_load_we; o_mem_addr = i_load_addr; o_mem_wdata = i_load_data, all combinational.
  - Each rising edge increments o_load_count, saturating at LOAD_WORDS.
  - Fetch requests are ignored and o_fetch_valid stays 0.
  - Go to DRAIN when i_start=1, or when the count reaches LOAD_WORDS and i_load_we=0 (the last burst has finished).
- DRAIN state:
  - o_mem_we=0. The drain counter counts DRAIN_CYCLES-1 down to 0.
  - Go to RUN when the counter is 0.
  - o_cpu_rst_n goes to 1 on the clock edge that enters RUN.
- RUN state:
  - o_mem_we=0; o_mem_addr = i_fetch_addr.
  - Every cycle with i_fetch_req=1 is accepted; back-to-back requests are allowed.
  - On the next cycle, o_fetch_valid=1 and o_fetch_instr = i_mem_rdata, registered at that edge. This gives 1-cycle latency, full throughput.
  - No request gives o_fetch_valid=0; o_fetch_instr holds its last value.
- Loader write outside LOAD: the rising edge of i_load_we in DRAIN or RUN sets o_drop_err (sticky). The write is not forwarded.
- i_reload in DRAIN or RUN:
  - Next state is LOAD; o_cpu_rst_n=0 and o_load_count=0 on the same edge.
  - o_fetch_valid is forced to 0 on that edge, and any in-flight fetch is discarded.
  - o_drop_err clears.
- i_reload in LOAD: clears o_load_count and o_drop_err; the state stays LOAD.
- Simultaneous events:
  - i_reload beats i_start.
  - i_start together with a load rising edge in LOAD: the write is forwarded and counted, then the state moves to DRAIN.
  - i_start in DRAIN or RUN is ignored.
- Address wrap: the loader address is used as-is with no range check. Writes beyond LOAD_WORDS bursts are still forwarded in LOAD but the count stays saturated.

Decomposition:
- Shared package: state encodings (LOAD/DRAIN/RUN), ADDR_W and DATA_W defaults, IMEM_DEPTH = 2**ADDR_W.
- One natural sub-module, imem_port_mux: the combinational selection of write/read onto the memory port by state. Sequencing, counters and the fetch pipeline stay in the top module.

Test Plan:
- Reset, then 8 loader bursts (each we high 3 cycles) at addr 0..7 with data 0x00000013+i -> o_load_count=8; DRAIN for 2 cycles; o_cpu_rst_n=1 on the following edge; o_state=2.
- RUN with back-to-back fetch addr 0,1,2 on consecutive cycles -> o_fetch_valid high 3 consecutive cycles, 1 cycle after each request, with instr 0x13, 0x14, 0x15.
- 3 bursts, then i_start -> DRAIN and RUN with o_load_count=3; words 3..7 read back as their prior memory contents.
- In RUN, loader burst to addr 2 data 0xDEADBEEF -> o_drop_err=1, o_mem_we stays 0, fetch of addr 2 still returns 0x15.
- In RUN, fetch in flight plus i_reload on the same cycle -> next cycle o_fetch_valid=0, o_cpu_rst_n=0, o_load_count=0, o_drop_err=0, o_state=0.
- Assert rst during DRAIN -> all outputs at reset values immediately (asynchronous); after release, state=LOAD and count=0.
